csr_access_ctrl: RTL and testbench
==================================

Name: csr_access_ctrl

Overview:
- Sequences CSR instructions (csrrd / csrwr / csrxchg) from the EX/MEM stage into a read-modify-write transaction.
- Each transaction reads the CSR file and drives the CSR write-data ALU, which merges mask and reserved-field bits.
- It then commits a single write and returns the old CSR value to the pipeline for GPR writeback.
- Exception and ertn commits from WB take priority and cancel any in-flight access, so a flushed instruction never writes a CSR.

Parameters:
- NUM_W, 14, CSR number width.
- DATA_W, 32, CSR/GPR data width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  CSR instruction request
- req_ready  out  1  controller can accept request
- req_op  in  2  00 csrrd, 01 csrwr, 10 csrxchg, 11 reserved (treated as csrrd)
- req_num  in  NUM_W  CSR number
- req_rd  in  DATA_W  rd source value (write data)
- req_rj  in  DATA_W  rj value (mask, csrxchg only)
- resp_valid  out  1  old-value response valid
- resp_ready  in  1  pipeline accepts response
- resp_data  out  DATA_W  CSR value before the write
- csr_rnum  out  NUM_W  CSR file read address
- csr_rdata  in  DATA_W  CSR file read data, combinational from csr_rnum
- alu_rd  out  DATA_W  to write-data ALU rd
- alu_rj  out  DATA_W  to write-data ALU rj
- alu_csr_data  out  DATA_W  to write-data ALU csr_data (old value)
- alu_num  out  NUM_W  to write-data ALU csr_num
- alu_mask_en  out  1  to write-data ALU mask_en
- alu_wd  in  DATA_W  merged write data from ALU
- csr_we  out  1  CSR file write enable, one-cycle pulse
- csr_wnum  out  NUM_W  CSR write address
- csr_wdata  out  DATA_W  CSR write data
- exc_commit  in  1  exception or ertn committing in WB (flush)
- busy  out  1  transaction in progress (state != IDLE)

Behaviour:
- States: IDLE, READ, WRITE, HOLD.
- Reset: state=IDLE; req_ready=0 during reset cycle, then follows IDLE rule; resp_valid=0, csr_we=0, busy=0, all registered data/number fields=0.
- req_ready = (state==IDLE) & ~exc_commit.
- Accept on req_valid & req_ready: latch op, num, rd, rj; go to READ.
- READ (1 cycle):
  - csr_rnum=num_q; old_q <= csr_rdata.
  - Go to WRITE unless exc_commit.
- WRITE (1 cycle):
  - alu_* driven from latched fields, with alu_csr_data=old_q and alu_mask_en=(op_q==10).
  - csr_we = (op_q is 01 or 10) & ~exc_commit; csr_wnum=num_q; csr_wdata=alu_wd.
  - resp_valid=1, resp_data=old_q.
  - If resp_ready, go to IDLE; else go to HOLD.
- HOLD:
  - resp_valid=1, resp_data stable, csr_we=0 (no second write).
  - Leave to IDLE on resp_ready.
- Latency: accept at cycle N, write/response at N+2, next accept at N+3. Peak throughput is 1 per 3 cycles.
- alu_* outputs are driven from latched fields in all states; only WRITE consumes alu_wd.
- exc_commit:
  - In READ or WRITE: abort, go to IDLE next cycle, no csr_we, no resp_valid in the aborted cycle.
  - In HOLD: the write has already committed and the response is dropped; go to IDLE.
  - In IDLE: blocks acceptance.
- A reserved op (11) behaves as csrrd: no write, old value returned.
- CSR numbers are passed through unmodified; reserved-field masking is the ALU's responsibility.
- Reset mid-transaction: go to IDLE with no write, regardless of state.

Test Plan:
- csrrd CRMD (num 0x0), csr_rdata=0x0000_0008, resp_ready=1 -> resp_valid at N+2 with resp_data=0x8; csr_we never asserted; req_ready high again at N+3.
- csrwr SAVE0 (0x30), rd=0xDEAD_BEEF, old=0x1111_1111, ALU instantiated -> csr_we pulse at N+2 with wnum=0x30, wdata=0xDEAD_BEEF; resp_data=0x1111_1111.
- csrxchg SAVE0, old=0x1234_5678, rd=0xFFFF_0000, rj=0x00FF_00FF -> alu_mask_en=1; wdata=0x12FF_5600; resp_data=0x1234_5678.
- csrwr ERA (0x6) with resp_ready=0 for 3 cycles -> exactly one csr_we pulse; resp_valid held 4 cycles with stable data; IDLE after resp_ready.
- exc_commit asserted in READ, then separately in WRITE, for csrwr -> no csr_we, no resp_valid, busy low next cycle; req_ready=0 while exc_commit=1 in IDLE.
- reset asserted during WRITE state -> csr_we=0 that cycle; all outputs at reset values the following cycle; a new request is accepted normally afterwards.

Source files
------------

// File: rtl/csr_access_ctrl.sv
// CSR instruction sequencer: read old value, drive the write-data ALU, commit one
// write and hand the old value back to the pipeline. WB flushes cancel in-flight work.
module csr_access_ctrl #(
    parameter int NUM_W  = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [NUM_W-1:0]  req_num,
    input  logic [DATA_W-1:0] req_rd,
    input  logic [DATA_W-1:0] req_rj,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [NUM_W-1:0]  csr_rnum,
    input  logic [DATA_W-1:0] csr_rdata,
    output logic [DATA_W-1:0] alu_rd,
    output logic [DATA_W-1:0] alu_rj,
    output logic [DATA_W-1:0] alu_csr_data,
    output logic [NUM_W-1:0]  alu_num,
    output logic              alu_mask_en,
    input  logic [DATA_W-1:0] alu_wd,
    output logic              csr_we,
    output logic [NUM_W-1:0]  csr_wnum,
    output logic [DATA_W-1:0] csr_wdata,
    input  logic              exc_commit,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [1:0] OP_CSRWR   = 2'b01;
    localparam logic [1:0] OP_CSRXCHG = 2'b10;

    state_t            state_reg;
    logic [1:0]        op_reg;
    logic [NUM_W-1:0]  num_reg;
    logic [DATA_W-1:0] rd_reg;
    logic [DATA_W-1:0] rj_reg;
    logic [DATA_W-1:0] old_reg;

    // Only csrwr and csrxchg write; the reserved op falls through as a read.
    logic op_writes;
    assign op_writes = (op_reg == OP_CSRWR) || (op_reg == OP_CSRXCHG);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            num_reg   <= '0;
            rd_reg    <= '0;
            rj_reg    <= '0;
            old_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op_reg    <= req_op;
                        num_reg   <= req_num;
                        rd_reg    <= req_rd;
                        rj_reg    <= req_rj;
                        state_reg <= READ;
                    end
                end
                READ: begin
                    old_reg   <= csr_rdata;
                    state_reg <= exc_commit ? IDLE : WRITE;
                end
                WRITE: begin
                    if (exc_commit || resp_ready)
                        state_reg <= IDLE;
                    else
                        state_reg <= HOLD;
                end
                HOLD: begin
                    // A flush here drops the response; the write already landed.
                    if (exc_commit || resp_ready)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_reg == IDLE) && !exc_commit && !reset;
    assign busy      = (state_reg != IDLE);

    assign csr_rnum     = num_reg;
    assign alu_rd       = rd_reg;
    assign alu_rj       = rj_reg;
    assign alu_csr_data = old_reg;
    assign alu_num      = num_reg;
    assign alu_mask_en  = (op_reg == OP_CSRXCHG);

    // Write and response are cancelled combinationally in the same cycle as a flush or reset.
    assign csr_we    = (state_reg == WRITE) && op_writes && !exc_commit && !reset;
    assign csr_wnum  = num_reg;
    assign csr_wdata = alu_wd;

    assign resp_valid = ((state_reg == WRITE) || (state_reg == HOLD)) && !exc_commit && !reset;
    assign resp_data  = old_reg;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl with a small CSR-file stub and write-data ALU model.
module tb_csr_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [13:0] req_num;
    logic [31:0] req_rd;
    logic [31:0] req_rj;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [13:0] csr_rnum;
    logic [31:0] csr_rdata;
    logic [31:0] alu_rd;
    logic [31:0] alu_rj;
    logic [31:0] alu_csr_data;
    logic [13:0] alu_num;
    logic        alu_mask_en;
    logic [31:0] alu_wd;
    logic        csr_we;
    logic [13:0] csr_wnum;
    logic [31:0] csr_wdata;
    logic        exc_commit;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;
    int we_cnt = 0;

    logic [31:0] crmd_val, save0_val, era_val;

    always #5 clk = ~clk;

    csr_access_ctrl #(.NUM_W(14), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_num(req_num), .req_rd(req_rd), .req_rj(req_rj),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .csr_rnum(csr_rnum), .csr_rdata(csr_rdata),
        .alu_rd(alu_rd), .alu_rj(alu_rj), .alu_csr_data(alu_csr_data),
        .alu_num(alu_num), .alu_mask_en(alu_mask_en), .alu_wd(alu_wd),
        .csr_we(csr_we), .csr_wnum(csr_wnum), .csr_wdata(csr_wdata),
        .exc_commit(exc_commit), .busy(busy)
    );

    // CSR file read stub, keyed on the read address
    assign csr_rdata = (csr_rnum == 14'h000) ? crmd_val  :
                       (csr_rnum == 14'h030) ? save0_val :
                       (csr_rnum == 14'h006) ? era_val   : 32'hBAD0_0000;

    // Write-data ALU: csrxchg merges rd into old under rj mask
    assign alu_wd = alu_mask_en ? ((alu_rd & alu_rj) | (alu_csr_data & ~alu_rj)) : alu_rd;

    always @(posedge clk) if (csr_we) we_cnt <= we_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE, confirm it is accepted on the next edge (now in READ)
    task automatic issue(input logic [1:0] op, input logic [13:0] num,
                         input logic [31:0] rd, input logic [31:0] rj, input string tag);
        req_valid = 1'b1; req_op = op; req_num = num; req_rd = rd; req_rj = rj;
        #1;
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        #1;
        check({tag, " busy in READ"}, 32'(busy), 32'd1);
    endtask

    int we_before;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_num = '0;
        req_rd = '0; req_rj = '0; resp_ready = 1'b1; exc_commit = 1'b0;
        crmd_val = 32'h0000_0008; save0_val = 32'h1111_1111; era_val = 32'hA5A5_0004;

        step();
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset csr_we", 32'(csr_we), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset resp_data", resp_data, 32'd0);
        reset = 1'b0;
        step();

        // csrrd CRMD
        we_before = we_cnt;
        issue(2'b00, 14'h000, 32'h0, 32'h0, "rd");
        check("rd rnum", 32'(csr_rnum), 32'h0);
        check("rd resp_valid in READ", 32'(resp_valid), 32'd0);
        step();
        check("rd resp_valid", 32'(resp_valid), 32'd1);
        check("rd resp_data", resp_data, 32'h0000_0008);
        check("rd csr_we", 32'(csr_we), 32'd0);
        step();
        check("rd req_ready N+3", 32'(req_ready), 32'd1);
        check("rd no writes", 32'(we_cnt - we_before), 32'd0);

        // csrwr SAVE0
        we_before = we_cnt;
        issue(2'b01, 14'h030, 32'hDEAD_BEEF, 32'h0, "wr");
        step();
        check("wr csr_we", 32'(csr_we), 32'd1);
        check("wr wnum", 32'(csr_wnum), 32'h30);
        check("wr wdata", csr_wdata, 32'hDEAD_BEEF);
        check("wr alu_num", 32'(alu_num), 32'h30);
        check("wr resp_data", resp_data, 32'h1111_1111);
        step();
        check("wr one write", 32'(we_cnt - we_before), 32'd1);

        // csrxchg SAVE0
        save0_val = 32'h1234_5678;
        issue(2'b10, 14'h030, 32'hFFFF_0000, 32'h00FF_00FF, "xchg");
        step();
        check("xchg mask_en", 32'(alu_mask_en), 32'd1);
        check("xchg csr_we", 32'(csr_we), 32'd1);
        check("xchg wdata", csr_wdata, 32'h12FF_5600);
        check("xchg resp_data", resp_data, 32'h1234_5678);
        step();

        // reserved op behaves as csrrd
        we_before = we_cnt;
        issue(2'b11, 14'h030, 32'h5555_5555, 32'hFFFF_FFFF, "rsv");
        step();
        check("rsv csr_we", 32'(csr_we), 32'd0);
        check("rsv mask_en", 32'(alu_mask_en), 32'd0);
        check("rsv resp_data", resp_data, 32'h1234_5678);
        step();
        check("rsv no writes", 32'(we_cnt - we_before), 32'd0);

        // csrwr ERA with response backpressure
        we_before = we_cnt;
        resp_ready = 1'b0;
        issue(2'b01, 14'h006, 32'h0000_1230, 32'h0, "bp");
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) resp_ready = 1'b1;
            #1;
            check($sformatf("bp resp_valid c%0d", i), 32'(resp_valid), 32'd1);
            check($sformatf("bp resp_data c%0d", i), resp_data, 32'hA5A5_0004);
            step();
        end
        check("bp one write", 32'(we_cnt - we_before), 32'd1);
        check("bp idle", 32'(busy), 32'd0);

        // flush in READ
        we_before = we_cnt;
        issue(2'b01, 14'h030, 32'h7777_7777, 32'h0, "excR");
        exc_commit = 1'b1;
        #1;
        check("excR resp_valid", 32'(resp_valid), 32'd0);
        step();
        exc_commit = 1'b0;
        #1;
        check("excR busy", 32'(busy), 32'd0);
        check("excR no write", 32'(we_cnt - we_before), 32'd0);

        // flush in WRITE
        issue(2'b01, 14'h030, 32'h8888_8888, 32'h0, "excW");
        step();
        exc_commit = 1'b1;
        #1;
        check("excW csr_we", 32'(csr_we), 32'd0);
        check("excW resp_valid", 32'(resp_valid), 32'd0);
        step();
        #1;
        check("excW busy", 32'(busy), 32'd0);
        check("excW no write", 32'(we_cnt - we_before), 32'd0);

        // flush in IDLE blocks acceptance
        req_valid = 1'b1; req_op = 2'b01; req_num = 14'h030;
        #1;
        check("excI req_ready", 32'(req_ready), 32'd0);
        step();
        req_valid = 1'b0; exc_commit = 1'b0;
        #1;
        check("excI not accepted", 32'(busy), 32'd0);

        // reset during WRITE
        we_before = we_cnt;
        issue(2'b01, 14'h030, 32'h9999_9999, 32'h0, "rst");
        step();
        reset = 1'b1;
        #1;
        check("rst csr_we", 32'(csr_we), 32'd0);
        step();
        check("rst busy", 32'(busy), 32'd0);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst resp_data", resp_data, 32'd0);
        check("rst wnum", 32'(csr_wnum), 32'd0);
        check("rst alu_rd", alu_rd, 32'd0);
        check("rst no write", 32'(we_cnt - we_before), 32'd0);
        reset = 1'b0;
        step();
        issue(2'b00, 14'h000, 32'h0, 32'h0, "post");
        step();
        check("post resp_data", resp_data, 32'h0000_0008);
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
